// File: rtl/fir_parallel_l2_ffa.sv
// fir_parallel_l2_ffa: 2-parallel fast-FIR (L=2) filter built from three half-length subfilters H0, H1, H0+H1.
// Define FIR_PARALLEL_ROUND_SAT_EN to round, shift by OUT_SHIFT and saturate the outputs; otherwise they wrap.
`timescale 1ns/1ps
module fir_parallel_l2_ffa #(
   parameter int DATA_IN_WIDTH = 16,
   parameter int DATA_OUT_WIDTH = 64,
   parameter int TAP_WIDTH = 32,
   parameter int TAP_COUNT = 51,
   parameter logic signed [TAP_WIDTH-1:0] TAPS [0:TAP_COUNT-1] = '{0: TAP_WIDTH'(1), default: '0},
   parameter int OUT_SHIFT = 0
) (
   input  logic                             clk,
   input  logic                             reset_n,
   input  logic                             in_valid,
   input  logic signed [DATA_IN_WIDTH-1:0]  in_data0,
   input  logic signed [DATA_IN_WIDTH-1:0]  in_data1,
   input  logic                             in_clear,
   output logic                             out_valid,
   output logic signed [DATA_OUT_WIDTH-1:0] out_data0,
   output logic signed [DATA_OUT_WIDTH-1:0] out_data1
);
   localparam int M = (TAP_COUNT + 1) / 2;
   localparam int XS_W = DATA_IN_WIDTH + 1;
   localparam int ACC_W = DATA_IN_WIDTH + TAP_WIDTH + 2 + $clog2(M);
   localparam int EXT_W = ACC_W > DATA_OUT_WIDTH ? ACC_W : DATA_OUT_WIDTH;

   logic signed [DATA_IN_WIDTH-1:0] x0_h [0:M-1];
   logic signed [DATA_IN_WIDTH-1:0] x1_h [0:M-1];
   logic signed [XS_W-1:0] xs_h [0:M-1];
   logic signed [ACC_W-1:0] pa [0:M-1];
   logic signed [ACC_W-1:0] pb [0:M-1];
   logic signed [ACC_W-1:0] pc [0:M-1];
   logic signed [ACC_W-1:0] sum_a, sum_b, sum_c;
   logic signed [ACC_W-1:0] a_q, b_q, c_q, bp_q;
   logic signed [EXT_W-1:0] y0, y1;
   logic v1, v2;

`ifdef FIR_PARALLEL_ROUND_SAT_EN
   localparam int R_W = EXT_W + 1;
   localparam logic signed [R_W-1:0] RND = OUT_SHIFT > 0 ? R_W'(1) <<< (OUT_SHIFT > 0 ? OUT_SHIFT - 1 : 0) : '0;
   localparam logic signed [R_W-1:0] MAXV = {{(R_W-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
   localparam logic signed [R_W-1:0] MINV = ~MAXV;

   function automatic logic signed [DATA_OUT_WIDTH-1:0] fmt(input logic signed [EXT_W-1:0] y);
      logic signed [R_W-1:0] r;
      r = (R_W'(y) + RND) >>> OUT_SHIFT;
      return r > MAXV ? MAXV[DATA_OUT_WIDTH-1:0] : (r < MINV ? MINV[DATA_OUT_WIDTH-1:0] : r[DATA_OUT_WIDTH-1:0]);
   endfunction
`else
   function automatic logic signed [DATA_OUT_WIDTH-1:0] fmt(input logic signed [EXT_W-1:0] y);
      return y[DATA_OUT_WIDTH-1:0];
   endfunction
`endif

   // per-tap products; odd TAP_COUNT pads H1 with a zero tap (the modulo only keeps the unused index in range)
   for (genvar j = 0; j < M; j++) begin : g_tap
      localparam logic signed [TAP_WIDTH-1:0] H0 = TAPS[2*j];
      localparam logic signed [TAP_WIDTH-1:0] H1 = (2*j+1 < TAP_COUNT) ? TAPS[(2*j+1) % TAP_COUNT] : '0;
      localparam logic signed [TAP_WIDTH:0] HS = (TAP_WIDTH+1)'(H0) + (TAP_WIDTH+1)'(H1);
      assign pa[j] = ACC_W'(H0) * ACC_W'(x0_h[j]);
      assign pb[j] = ACC_W'(H1) * ACC_W'(x1_h[j]);
      assign pc[j] = ACC_W'(HS) * ACC_W'(xs_h[j]);
   end

   // subfilter sums over the block-indexed delay lines
   always_comb begin
      sum_a = '0;
      sum_b = '0;
      sum_c = '0;
      for (int i = 0; i < M; i++) begin
         sum_a = sum_a + pa[i];
         sum_b = sum_b + pb[i];
         sum_c = sum_c + pc[i];
      end
   end

   // S1: input registers double as the head of each delay line; shift only on accepted blocks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1 <= 1'b0;
         for (int i = 0; i < M; i++) begin
            x0_h[i] <= '0;
            x1_h[i] <= '0;
            xs_h[i] <= '0;
         end
      end else if (in_clear) begin
         v1 <= 1'b0;
         for (int i = 0; i < M; i++) begin
            x0_h[i] <= '0;
            x1_h[i] <= '0;
            xs_h[i] <= '0;
         end
      end else begin
         v1 <= in_valid;
         if (in_valid) begin
            x0_h[0] <= in_data0;
            x1_h[0] <= in_data1;
            xs_h[0] <= XS_W'(in_data0) + XS_W'(in_data1);
            for (int i = 1; i < M; i++) begin
               x0_h[i] <= x0_h[i-1];
               x1_h[i] <= x1_h[i-1];
               xs_h[i] <= xs_h[i-1];
            end
         end
      end
   end

   // S2: capture A, B, C of the current block and keep B of the previous block
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v2 <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         bp_q <= '0;
      end else if (in_clear) begin
         v2 <= 1'b0;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         bp_q <= '0;
      end else begin
         v2 <= v1;
         if (v1) begin
            a_q <= sum_a;
            b_q <= sum_b;
            c_q <= sum_c;
            bp_q <= b_q;
         end
      end
   end

   assign y0 = EXT_W'(a_q) + EXT_W'(bp_q);
   assign y1 = EXT_W'(c_q) - EXT_W'(a_q) - EXT_W'(b_q);

   // S3: post-add and output format; data holds between valid pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data0 <= '0;
         out_data1 <= '0;
      end else begin
         out_valid <= v2 & ~in_clear;
         if (v2 & ~in_clear) begin
            out_data0 <= fmt(y0);
            out_data1 <= fmt(y1);
         end
      end
   end
endmodule

// File: tb/tb_fir_parallel_l2_ffa.sv
// tb_fir_parallel_l2_ffa: directed table, reset and random-vs-direct-form checks for fir_parallel_l2_ffa
`timescale 1ns/1ps
module tb_fir_parallel_l2_ffa;
   localparam logic signed [31:0] TAPS_A [0:2] = '{1, 2, 3};
   localparam logic signed [31:0] TAPS_E [0:3] = '{5, -3, 7, 2};
   localparam logic signed [31:0] TAPS_B [0:50] = '{
      1, -2, 3, 1000, -70000, 123456, -987654, 2000000000, -1999999999, 42,
      0, 7, -8, 65535, -65536, 305419896, -559038737, 16777215, -16777216, 99,
      -99, 1, 0, 0, 31337, -31337, 1073741823, -1073741824, 5, 6,
      -7, 8, 1500000000, -1500000000, 271828, -314159, 11, -13, 17, -19,
      23, 123456789, -123456789, 2, -3, 4, -5, 6, 77777, -88888,
      2147483647};
`ifdef FIR_PARALLEL_ROUND_SAT_EN
   localparam longint OV10 = 127, OV11 = 127, OV20 = 127, OV21 = 127;
`else
   localparam longint OV10 = 127, OV11 = 125, OV20 = -6, OV21 = -6;
`endif

   logic clk = 1'b0;
   logic reset_n;
   logic in_valid, in_clear;
   logic signed [15:0] in_data0, in_data1;
   logic a_v, o_v, b_v, e_v;
   logic signed [63:0] a0, a1, b0, b1, e0, e1;
   logic signed [7:0] o0, o1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fir_parallel_l2_ffa #(.DATA_OUT_WIDTH(64), .TAP_COUNT(3), .TAPS(TAPS_A)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
      .in_clear(in_clear), .out_valid(a_v), .out_data0(a0), .out_data1(a1));
   fir_parallel_l2_ffa #(.DATA_OUT_WIDTH(8), .TAP_COUNT(3), .TAPS(TAPS_A), .OUT_SHIFT(0)) dut_o (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
      .in_clear(in_clear), .out_valid(o_v), .out_data0(o0), .out_data1(o1));
   fir_parallel_l2_ffa #(.DATA_OUT_WIDTH(64), .TAP_COUNT(51), .TAPS(TAPS_B)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
      .in_clear(in_clear), .out_valid(b_v), .out_data0(b0), .out_data1(b1));
   fir_parallel_l2_ffa #(.DATA_OUT_WIDTH(64), .TAP_COUNT(4), .TAPS(TAPS_E)) dut_e (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data0(in_data0), .in_data1(in_data1),
      .in_clear(in_clear), .out_valid(e_v), .out_data0(e0), .out_data1(e1));

   typedef struct {
      logic v, c;
      int d0, d1;
      logic ev;
      longint a0, a1, o0, o1;
   } row_t;
   typedef struct {
      int due;
      longint b0, b1, e0, e1;
   } exp_t;

   row_t tbl[$];
   exp_t q[$];
   longint hist[$];

   function automatic void chk(string nm, logic signed [63:0] act, logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endfunction

   task automatic r(input logic v, c, input int d0, d1, input logic ev, input longint xa0, xa1, xo0, xo1);
      tbl.push_back('{v, c, d0, d1, ev, xa0, xa1, xo0, xo1});
   endtask

   task automatic ra(input logic v, c, input int d0, d1, input logic ev, input longint xa0, xa1);
      r(v, c, d0, d1, ev, xa0, xa1, xa0, xa1);
   endtask

   function automatic longint model(input bit big, input int n);
      longint s = 0;
      int nt = big ? 51 : 4;
      for (int i = 0; i < nt; i++)
         if (n - i >= 0) s += (big ? longint'(TAPS_B[i]) : longint'(TAPS_E[i])) * hist[n-i];
      return s;
   endfunction

   initial begin
      // per-cycle rows: inputs driven this cycle, outputs expected before they are sampled
      ra(1,0,1,0, 0,0,0); ra(1,0,0,0, 0,0,0); ra(1,0,0,0, 0,0,0);
      ra(0,0,0,0, 1,1,2); ra(0,0,0,0, 1,3,0); ra(0,0,0,0, 1,0,0);
      ra(1,0,1,1, 0,0,0); ra(1,0,1,1, 0,0,0); ra(1,0,1,1, 0,0,0);
      ra(1,0,1,1, 1,1,3); ra(0,0,0,0, 1,6,6); ra(0,0,0,0, 1,6,6);
      ra(0,0,0,0, 1,6,6); ra(0,0,0,0, 0,6,6); ra(0,1,0,0, 0,6,6);
      ra(1,0,1,1, 0,6,6); ra(0,0,0,0, 0,6,6); ra(0,0,0,0, 0,6,6);
      ra(1,0,1,1, 1,1,3); ra(0,0,0,0, 0,1,3); ra(0,0,0,0, 0,1,3);
      ra(1,0,1,1, 1,6,6); ra(0,0,0,0, 0,6,6); ra(0,0,0,0, 0,6,6);
      ra(1,0,1,1, 1,6,6); ra(0,0,0,0, 0,6,6); ra(0,0,0,0, 0,6,6);
      ra(0,0,0,0, 1,6,6); ra(0,1,0,0, 0,6,6);
      ra(1,0,1,1, 0,6,6); ra(1,0,1,1, 0,6,6); ra(1,0,1,1, 0,6,6);
      ra(1,0,1,1, 1,1,3); ra(1,0,1,1, 1,6,6); ra(1,1,1,1, 1,6,6);
      ra(1,0,1,0, 0,6,6); ra(0,0,0,0, 0,6,6); ra(0,0,0,0, 0,6,6);
      ra(0,0,0,0, 1,1,2); ra(0,0,0,0, 0,1,2);
      ra(0,1,0,0, 0,1,2); ra(1,0,127,127, 0,1,2); ra(1,0,127,127, 0,1,2);
      ra(0,0,0,0, 0,1,2);
      r(0,0,0,0, 1,127,381,OV10,OV11); r(0,0,0,0, 1,762,762,OV20,OV21);
      r(0,0,0,0, 0,762,762,OV20,OV21);

      reset_n = 1'b0;
      in_valid = 1'b0;
      in_clear = 1'b0;
      in_data0 = '0;
      in_data1 = '0;
      #1;
      chk("rst_a_valid", a_v, 0); chk("rst_a0", a0, 0); chk("rst_a1", a1, 0);
      chk("rst_o_valid", o_v, 0); chk("rst_o0", o0, 0); chk("rst_o1", o1, 0);
      chk("rst_b_valid", b_v, 0); chk("rst_b0", b0, 0); chk("rst_e_valid", e_v, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         chk($sformatf("tbl%0d_a_valid", i), a_v, tbl[i].ev);
         chk($sformatf("tbl%0d_a0", i), a0, tbl[i].a0);
         chk($sformatf("tbl%0d_a1", i), a1, tbl[i].a1);
         chk($sformatf("tbl%0d_o_valid", i), o_v, tbl[i].ev);
         chk($sformatf("tbl%0d_o0", i), o0, tbl[i].o0);
         chk($sformatf("tbl%0d_o1", i), o1, tbl[i].o1);
         in_valid = tbl[i].v;
         in_clear = tbl[i].c;
         in_data0 = 16'(tbl[i].d0);
         in_data1 = 16'(tbl[i].d1);
      end

      // asynchronous reset in the middle of a stream
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_clear = 1'b0;
         in_data0 = 16'sd1;
         in_data1 = 16'sd1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("pre_rst_a_valid", a_v, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_a_valid", a_v, 0); chk("mid_rst_a0", a0, 0); chk("mid_rst_a1", a1, 0);
      chk("mid_rst_o_valid", o_v, 0); chk("mid_rst_o0", o0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post_rst%0d_a_valid", i), a_v, 0);
         chk($sformatf("post_rst%0d_b_valid", i), b_v, 0);
      end

      // random blocks with idle gaps against direct-form models
      begin
         int acc = 0;
         int cyc = 0;
         while (cyc < 4000 && (acc < 1000 || q.size() > 0)) begin
            logic ev;
            @(negedge clk);
            ev = q.size() > 0 && q[0].due == cyc;
            chk($sformatf("rand%0d_b_valid", cyc), b_v, ev);
            chk($sformatf("rand%0d_e_valid", cyc), e_v, ev);
            if (ev) begin
               chk($sformatf("rand%0d_b0", cyc), b0, q[0].b0);
               chk($sformatf("rand%0d_b1", cyc), b1, q[0].b1);
               chk($sformatf("rand%0d_e0", cyc), e0, q[0].e0);
               chk($sformatf("rand%0d_e1", cyc), e1, q[0].e1);
               void'(q.pop_front());
            end
            if (acc < 1000 && $urandom_range(3) != 0) begin
               int n;
               in_valid = 1'b1;
               in_data0 = 16'($urandom);
               in_data1 = 16'($urandom);
               hist.push_back(longint'(in_data0));
               hist.push_back(longint'(in_data1));
               n = hist.size();
               q.push_back('{cyc + 3, model(1, n-2), model(1, n-1), model(0, n-2), model(0, n-1)});
               acc++;
            end else begin
               in_valid = 1'b0;
            end
            cyc++;
         end
         chk("rand_drain", q.size(), 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
